// File: rtl/telem_frame_serializer_if.sv
// telem_frame_serializer_if: registered word bus toward the FT600 ui_din
// port, with the downstream full flag as backpressure.
interface telem_frame_serializer_if #(
   parameter int BUS_WIDTH = 16
);
   logic [BUS_WIDTH-1:0]   out_data;
   logic [BUS_WIDTH/8-1:0] out_be;
   logic                   out_valid;
   logic                   out_full;

   modport master (
      output out_data,
      output out_be,
      output out_valid,
      input  out_full
   );

   modport slave (
      input  out_data,
      input  out_be,
      input  out_valid,
      output out_full
   );
endinterface

// File: rtl/telem_frame_serializer.sv
// telem_frame_serializer: packet FIFO, frame slicer (data/MAGIC/SEQ) and
// PC loopback mux. Define TELEM_SER_CHECKSUM_EN to append an XOR word.
module telem_frame_serializer #(
   parameter int                   PKT_WIDTH = 88,
   parameter int                   BUS_WIDTH = 16,
   parameter int                   DEPTH     = 4,
   parameter logic [7:0]           PAD_BYTE  = 8'h7C,
   parameter logic [BUS_WIDTH-1:0] MAGIC     = 16'hDEC0,
   parameter logic [BUS_WIDTH-1:0] IDLE_WORD = 16'hBCBC,
   parameter int                   CNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [PKT_WIDTH-1:0]   pkt_data,
   input  logic                   pkt_valid,
   input  logic                   stream_mode,
   input  logic [BUS_WIDTH-1:0]   loop_din,
   input  logic [BUS_WIDTH/8-1:0] loop_din_be,
   input  logic                   loop_empty,
   output logic                   loop_get,
   telem_frame_serializer_if.master out_bus,
   input  logic                   clear_status,
   output logic [CNT_WIDTH-1:0]   drop_count,
   output logic                   sticky_overflow
);

   localparam int W   = (PKT_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
   localparam int PW  = W * BUS_WIDTH;
   localparam int BEW = BUS_WIDTH / 8;
   localparam int AW  = $clog2(DEPTH);
   localparam int KW  = (W > 1) ? $clog2(W) : 1;

   typedef logic [PW-1:0] frame_t;

   typedef struct packed {
      logic [PKT_WIDTH-1:0] pkt;
      logic [BUS_WIDTH-1:0] seq;
   } entry_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DATA,
      S_MAGIC,
      S_SEQ,
`ifdef TELEM_SER_CHECKSUM_EN
      S_CSUM,
`endif
      S_LOOP
   } state_t;

   function automatic frame_t pad(
      input logic [PKT_WIDTH-1:0] p
   );
      frame_t f;
      f = {(PW/8){PAD_BYTE}};
      f[PKT_WIDTH-1:0] = p;
      return f;
   endfunction

   entry_t               mem [DEPTH];
   logic [AW:0]          wr_ptr;
   logic [AW:0]          rd_ptr;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic                 fifo_wr;
   logic                 drop;
   entry_t               head;
   frame_t               head_pad;

   logic [BUS_WIDTH-1:0] seq;

   state_t               state;
   state_t               state_nx;
   logic [KW-1:0]        k;
   logic [KW-1:0]        k_nx;
   logic                 pop;
   frame_t               frm_data;
   logic [BUS_WIDTH-1:0] frm_seq;
   logic [BUS_WIDTH-1:0] word_sel;

   logic                 emit;
   logic [BUS_WIDTH-1:0] emit_data;
   logic [BEW-1:0]       emit_be;
   logic                 ld_ok;

   logic                 out_valid_q;
   logic [BUS_WIDTH-1:0] out_data_q;
   logic [BEW-1:0]       out_be_q;

`ifdef TELEM_SER_CHECKSUM_EN
   logic [BUS_WIDTH-1:0] csum;
`endif

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign fifo_wr    = pkt_valid && stream_mode && !fifo_full;
   assign drop       = pkt_valid && stream_mode && fifo_full;
   assign head       = mem[rd_ptr[AW-1:0]];
   assign head_pad   = pad(head.pkt);
   assign word_sel   = frm_data[int'(k)*BUS_WIDTH +: BUS_WIDTH];

   assign ld_ok = !out_valid_q || !out_bus.out_full;

   assign out_bus.out_valid = out_valid_q;
   assign out_bus.out_data  = out_data_q;
   assign out_bus.out_be    = out_be_q;

   // packet storage; each entry keeps the seq value seen at its strobe
   always_ff @(posedge clk) begin
      if (fifo_wr) begin
         mem[wr_ptr[AW-1:0]] <= '{pkt: pkt_data, seq: seq};
      end
   end

   // FIFO pointers and the per-strobe sequence counter
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         seq    <= '0;
      end else begin
         if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (pkt_valid) seq <= seq + 1'b1;
      end
   end

   // drop accounting; a clear that meets a drop leaves exactly one
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_count      <= '0;
         sticky_overflow <= 1'b0;
      end else if (clear_status) begin
         drop_count      <= CNT_WIDTH'(drop);
         sticky_overflow <= drop;
      end else if (drop) begin
         if (drop_count != '1) begin
            drop_count <= drop_count + 1'b1;
         end
         sticky_overflow <= 1'b1;
      end
   end

`ifdef TELEM_SER_CHECKSUM_EN
   // XOR of the padded data words, MAGIC and SEQ of the current frame
   always_comb begin
      csum = MAGIC ^ frm_seq;
      for (int i = 0; i < W; i++) begin
         csum = csum ^ frm_data[i*BUS_WIDTH +: BUS_WIDTH];
      end
   end
`endif

   // frame register captures the FIFO head as word 0 goes out
   always_ff @(posedge clk) begin
      if (pop) begin
         frm_data <= head_pad;
         frm_seq  <= head.seq;
      end
   end

   // FSM state and data word index
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         k     <= '0;
      end else begin
         state <= state_nx;
         k     <= k_nx;
      end
   end

   // next state, word selection and loopback pop
   always_comb begin
      state_nx  = state;
      k_nx      = k;
      pop       = 1'b0;
      loop_get  = 1'b0;
      emit      = 1'b0;
      emit_data = IDLE_WORD;
      emit_be   = '1;
      unique case (state)
         S_IDLE: begin
            if (!stream_mode) begin
               state_nx = S_LOOP;
            end else if (!fifo_empty && ld_ok) begin
               pop       = 1'b1;
               emit      = 1'b1;
               emit_data = head_pad[BUS_WIDTH-1:0];
               k_nx      = KW'(1);
               state_nx  = (W == 1) ? S_MAGIC : S_DATA;
            end
         end
         S_DATA: begin
            if (ld_ok) begin
               emit      = 1'b1;
               emit_data = word_sel;
               if (k == KW'(W-1)) begin
                  state_nx = S_MAGIC;
               end else begin
                  k_nx = k + 1'b1;
               end
            end
         end
         S_MAGIC: begin
            if (ld_ok) begin
               emit      = 1'b1;
               emit_data = MAGIC;
               state_nx  = S_SEQ;
            end
         end
         S_SEQ: begin
            if (ld_ok) begin
               emit      = 1'b1;
               emit_data = frm_seq;
`ifdef TELEM_SER_CHECKSUM_EN
               state_nx  = S_CSUM;
`else
               state_nx  = S_IDLE;
`endif
            end
         end
`ifdef TELEM_SER_CHECKSUM_EN
         S_CSUM: begin
            if (ld_ok) begin
               emit      = 1'b1;
               emit_data = csum;
               state_nx  = S_IDLE;
            end
         end
`endif
         S_LOOP: begin
            loop_get = !loop_empty && ld_ok;
            if (loop_get) begin
               emit      = 1'b1;
               emit_data = loop_din;
               emit_be   = loop_din_be;
            end
            if (stream_mode) begin
               state_nx = S_IDLE;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // output register; only loads when the held word is free to move
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= IDLE_WORD;
         out_be_q    <= '1;
      end else if (ld_ok) begin
         out_valid_q <= emit;
         out_data_q  <= emit ? emit_data : IDLE_WORD;
         out_be_q    <= emit ? emit_be : '1;
      end
   end

endmodule

// File: tb/tb_telem_frame_serializer.sv
// tb_telem_frame_serializer: directed vectors with hand-computed frames
// for telem_frame_serializer (default parameters).
module tb_telem_frame_serializer;

`ifdef TELEM_SER_CHECKSUM_EN
   localparam int NF = 9;
`else
   localparam int NF = 8;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [87:0] pkt_data;
   logic        pkt_valid;
   logic        stream_mode;
   logic [15:0] loop_din;
   logic [1:0]  loop_din_be;
   logic        loop_empty;
   logic        loop_get;
   logic        clear_status;
   logic [15:0] drop_count;
   logic        sticky_overflow;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] lw [2] = '{16'h1111, 16'h2222};
   logic [1:0]  lb [2] = '{2'b11, 2'b01};
   logic        loop_en = 1'b0;
   int          li = 0;

   logic [15:0] f1 [9] = '{16'h0100, 16'h0302, 16'h0504,
                           16'h0706, 16'h0908, 16'h7C0A,
                           16'hDEC0, 16'h0000, 16'hABC2};

   telem_frame_serializer_if #(.BUS_WIDTH(16)) ob ();

   telem_frame_serializer dut (
      .clk             (clk),
      .rst             (rst),
      .pkt_data        (pkt_data),
      .pkt_valid       (pkt_valid),
      .stream_mode     (stream_mode),
      .loop_din        (loop_din),
      .loop_din_be     (loop_din_be),
      .loop_empty      (loop_empty),
      .loop_get        (loop_get),
      .out_bus         (ob),
      .clear_status    (clear_status),
      .drop_count      (drop_count),
      .sticky_overflow (sticky_overflow)
   );

   always #5 clk = ~clk;

   // loopback source: two queued words, popped on loop_get
   assign loop_empty  = !loop_en || (li >= 2);
   assign loop_din    = (li < 2) ? lw[li] : 16'h0000;
   assign loop_din_be = (li < 2) ? lb[li] : 2'b00;

   always @(posedge clk) begin
      if (loop_get) li <= li + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] fword(input logic [87:0] p,
                                         input logic [15:0] s,
                                         input int i);
      logic [95:0] pd;
      logic [15:0] x;
      pd = {8'h7C, p};
      if (i < 6) return pd[i*16 +: 16];
      if (i == 6) return 16'hDEC0;
      if (i == 7) return s;
      x = 16'hDEC0 ^ s;
      for (int j = 0; j < 6; j++) x = x ^ pd[j*16 +: 16];
      return x;
   endfunction

   task automatic send(input logic [87:0] p);
      pkt_data  = p;
      pkt_valid = 1'b1;
      step();
      pkt_valid = 1'b0;
   endtask

   task automatic expect_frame(input string tag,
                               input logic [87:0] p,
                               input logic [15:0] s);
      for (int i = 0; i < NF; i++) begin
         chk({tag, "_v"}, 32'(ob.out_valid), 32'd1);
         chk({tag, "_d"}, 32'(ob.out_data), 32'(fword(p, s, i)));
         step();
      end
   endtask

   localparam logic [87:0] P2 = 88'h11_2233_4455_6677_8899_AABB;
   localparam logic [87:0] P3 = 88'hFE_DCBA_9876_5432_10F0_E1D2;
   localparam logic [87:0] P4 = 88'h5A_A55A_A55A_A55A_A55A_A55A;
   localparam logic [87:0] P5 = 88'h01_0203_0405_0607_0809_0A0B;
   localparam logic [87:0] P6 = 88'hC3_3CC3_3CC3_3CC3_3CC3_3CC3;

   function automatic logic [87:0] cp(input int i);
      return {8'(i), 80'h0, 16'h1000 + 16'(i)};
   endfunction

   initial begin
      rst          = 1'b1;
      pkt_data     = '0;
      pkt_valid    = 1'b0;
      stream_mode  = 1'b1;
      clear_status = 1'b0;
      ob.out_full  = 1'b0;
      step();
      step();

      chk("rst_valid", 32'(ob.out_valid), 32'd0);
      chk("rst_data", 32'(ob.out_data), 32'hBCBC);
      chk("rst_be", 32'(ob.out_be), 32'h3);
      chk("rst_loop_get", 32'(loop_get), 32'd0);
      chk("rst_drop", 32'(drop_count), 32'd0);
      chk("rst_sticky", 32'(sticky_overflow), 32'd0);

      rst = 1'b0;
      step();

      // frame latency and hand-computed words
      send(88'h0A_0908_0706_0504_0302_0100);
      chk("lat_c1", 32'(ob.out_valid), 32'd0);
      step();
      for (int i = 0; i < NF; i++) begin
         chk("f1_valid", 32'(ob.out_valid), 32'd1);
         chk("f1_data", 32'(ob.out_data), 32'(f1[i]));
         chk("f1_be", 32'(ob.out_be), 32'h3);
         step();
      end
      chk("f1_end_valid", 32'(ob.out_valid), 32'd0);
      chk("f1_end_data", 32'(ob.out_data), 32'hBCBC);

      send(P2);
      step();
      expect_frame("f2", P2, 16'h0001);
      chk("f2_end", 32'(ob.out_valid), 32'd0);

      // backpressure while word 3 is held
      send(P3);
      step();
      step();
      step();
      step();
      chk("stall_w3", 32'(ob.out_data), 32'(fword(P3, 16'h0002, 3)));
      ob.out_full = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         chk("stall_hold_v", 32'(ob.out_valid), 32'd1);
         chk("stall_hold_d", 32'(ob.out_data),
             32'(fword(P3, 16'h0002, 3)));
      end
      ob.out_full = 1'b0;
      step();
      for (int i = 4; i < NF; i++) begin
         chk("stall_rest_v", 32'(ob.out_valid), 32'd1);
         chk("stall_rest_d", 32'(ob.out_data),
             32'(fword(P3, 16'h0002, i)));
         step();
      end
      chk("stall_end", 32'(ob.out_valid), 32'd0);

      // capacity with output stalled from reset
      rst = 1'b1;
      ob.out_full = 1'b1;
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 7; i++) begin
         send(cp(i));
         step();
      end
      chk("cap_drop", 32'(drop_count), 32'd2);
      chk("cap_sticky", 32'(sticky_overflow), 32'd1);
      chk("cap_held", 32'(ob.out_data), 32'(fword(cp(0), 16'h0, 0)));

      clear_status = 1'b1;
      send(cp(7));
      clear_status = 1'b0;
      chk("clr_drop_cnt", 32'(drop_count), 32'd1);
      chk("clr_drop_stk", 32'(sticky_overflow), 32'd1);
      clear_status = 1'b1;
      step();
      clear_status = 1'b0;
      chk("clr_cnt", 32'(drop_count), 32'd0);
      chk("clr_stk", 32'(sticky_overflow), 32'd0);

      ob.out_full = 1'b0;
      for (int i = 0; i < 5; i++) begin
         expect_frame("cap_f", cp(i), 16'(i));
      end
      chk("cap_end", 32'(ob.out_valid), 32'd0);

      // loopback
      stream_mode = 1'b0;
      step();
      chk("lb_get_empty", 32'(loop_get), 32'd0);
      send(P4);
      chk("lb_no_drop", 32'(drop_count), 32'd0);
      loop_en = 1'b1;
      #1;
      chk("lb_get0", 32'(loop_get), 32'd1);
      step();
      chk("lb_d0", 32'(ob.out_data), 32'h1111);
      chk("lb_be0", 32'(ob.out_be), 32'h3);
      chk("lb_v0", 32'(ob.out_valid), 32'd1);
      chk("lb_get1", 32'(loop_get), 32'd1);
      step();
      chk("lb_d1", 32'(ob.out_data), 32'h2222);
      chk("lb_be1", 32'(ob.out_be), 32'h1);
      chk("lb_get2", 32'(loop_get), 32'd0);
      step();
      chk("lb_end_v", 32'(ob.out_valid), 32'd0);
      chk("lb_end_d", 32'(ob.out_data), 32'hBCBC);
      chk("lb_end_be", 32'(ob.out_be), 32'h3);
      stream_mode = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("lb_not_sent", 32'(ob.out_valid), 32'd0);
      end
      chk("lb_drop_final", 32'(drop_count), 32'd0);

      // seq advanced across the discarded strobe
      send(P5);
      step();
      expect_frame("f_after_lb", P5, 16'h0009);

      // reset mid-frame at word 4
      send(P6);
      step();
      for (int i = 0; i < 4; i++) begin
         chk("mid_d", 32'(ob.out_data), 32'(fword(P6, 16'h000A, i)));
         step();
      end
      chk("mid_w4", 32'(ob.out_data), 32'(fword(P6, 16'h000A, 4)));
      rst = 1'b1;
      step();
      chk("mid_rst_v", 32'(ob.out_valid), 32'd0);
      chk("mid_rst_d", 32'(ob.out_data), 32'hBCBC);
      rst = 1'b0;
      step();
      chk("mid_idle", 32'(ob.out_valid), 32'd0);
      send(P2);
      step();
      expect_frame("f_after_rst", P2, 16'h0000);
      chk("final_idle", 32'(ob.out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
